// File: rtl/voice_allocator.sv
// Voice allocator: scans the voice pool once per MIDI event and picks retrigger / free / releasing / steal targets.
// Latency: event accepted at T, VOICES scan cycles, note-on strobe at T+VOICES+1, ev_ready high again at T+VOICES+2.
// Backpressure: ev_ready is low from acceptance until the assign cycle completes (and during a sustain release sweep).
//
// Ports: CLOCK_50/reset_n (async active-low); ev_valid/ev_ready/ev_on/ev_note/ev_vel event input;
//        voice_free per-voice envelope-silent flags; asg_* assignment strobe and payload; keys_on key-held vector.
// Optional: define SUSTAIN_PEDAL_EN to add the sustain input, per-voice held flags and the RELEASE sweep.
module voice_allocator #(
    parameter int VOICES = 32,
    parameter int AGE_W  = 8
) (
    input  logic                      CLOCK_50,
    input  logic                      reset_n,
    input  logic                      ev_valid,
    output logic                      ev_ready,
    input  logic                      ev_on,
    input  logic [6:0]                ev_note,
    input  logic [6:0]                ev_vel,
    input  logic [VOICES-1:0]         voice_free,
`ifdef SUSTAIN_PEDAL_EN
    input  logic                      sustain,
`endif
    output logic                      asg_valid,
    output logic                      asg_on,
    output logic [$clog2(VOICES)-1:0] asg_voice,
    output logic [6:0]                asg_note,
    output logic [6:0]                asg_vel,
    output logic                      asg_steal,
    output logic [VOICES-1:0]         keys_on
);

    localparam int VW = $clog2(VOICES);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    // Candidate class rank: larger is better.
    localparam logic [1:0] CLS_S = 2'd0;
    localparam logic [1:0] CLS_L = 2'd1;
    localparam logic [1:0] CLS_F = 2'd2;
    localparam logic [1:0] CLS_R = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        ASSIGN = 2'd2
`ifdef SUSTAIN_PEDAL_EN
        , RELEASE = 2'd3
`endif
    } state_t;

    state_t state, state_nx;

    logic [VW-1:0]    idx;
    logic             lat_on;
    logic [6:0]       lat_note;
    logic [6:0]       lat_vel;
    logic [VW-1:0]    cand_idx;
    logic [1:0]       cand_cls;
    logic [AGE_W-1:0] cand_age;
    logic [6:0]       note_tab [VOICES];
    logic [AGE_W-1:0] age_tab  [VOICES];
    logic [VW-1:0]    hold_voice;
    logic [6:0]       hold_note;
    logic [6:0]       hold_vel;

    logic             accept;
    logic             last;
    logic [1:0]       cur_cls;
    logic [AGE_W-1:0] cur_age;
    logic             take;
    logic [VW-1:0]    nx_idx;
    logic [1:0]       nx_cls;
    logic [AGE_W-1:0] nx_age;
    logic             noff_hit;
    logic             noff_pulse;
    logic             on_pulse;
    logic             sus_lvl;
    logic             rel_req;
    logic             rel_hit;

`ifdef SUSTAIN_PEDAL_EN
    logic [VOICES-1:0] held;
    logic              sus_q;
    logic              sus_pend;

    assign sus_lvl = sustain;
    // A falling edge that arrives while busy is remembered until IDLE.
    assign rel_req = sus_pend | (sus_q & ~sustain);
    assign rel_hit = (state == RELEASE) & held[idx];
`else
    assign sus_lvl = 1'b0;
    assign rel_req = 1'b0;
    assign rel_hit = 1'b0;
`endif

    assign accept = ev_valid & ev_ready;
    assign last   = (idx == VW'(VOICES - 1));

    // Candidate evaluation for the voice under the scan index.
    always_comb begin
        cur_age = age_tab[idx];
        if (keys_on[idx]) begin
            cur_cls = (note_tab[idx] == lat_note) ? CLS_R : CLS_S;
        end else begin
            cur_cls = voice_free[idx] ? CLS_F : CLS_L;
        end
        // Index 0 seeds the candidate; strict compares keep the lowest index on ties.
        // Free voices carry no meaningful age, so F never competes on age.
        take = (idx == '0) | (cur_cls > cand_cls) |
               ((cur_cls == cand_cls) & (cur_cls != CLS_F) & (cur_age > cand_age));
        nx_idx = take ? idx     : cand_idx;
        nx_cls = take ? cur_cls : cand_cls;
        nx_age = take ? cur_age : cand_age;
    end

    assign noff_hit   = (state == SCAN) & ~lat_on & keys_on[idx] & (note_tab[idx] == lat_note);
    assign noff_pulse = noff_hit & ~sus_lvl;
    assign on_pulse   = (state == ASSIGN) & lat_on;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        ev_ready  = 1'b0;
        asg_valid = noff_pulse | rel_hit | on_pulse;
        asg_on    = on_pulse;
        asg_steal = on_pulse & (cand_cls == CLS_S);
        asg_voice = hold_voice;
        asg_note  = hold_note;
        asg_vel   = hold_vel;
        if (on_pulse) begin
            asg_voice = cand_idx;
            asg_note  = lat_note;
            asg_vel   = lat_vel;
        end else if (noff_pulse) begin
            asg_voice = idx;
            asg_note  = lat_note;
            asg_vel   = lat_vel;
        end else if (rel_hit) begin
            asg_voice = idx;
            asg_note  = note_tab[idx];
            asg_vel   = 7'd0;
        end
        case (state)
            IDLE: begin
                ev_ready = ~rel_req;
`ifdef SUSTAIN_PEDAL_EN
                if (rel_req) state_nx = RELEASE;
                else
`endif
                if (ev_valid) state_nx = SCAN;
            end
            SCAN: begin
                if (last) state_nx = ASSIGN;
            end
            ASSIGN: begin
                state_nx = IDLE;
            end
`ifdef SUSTAIN_PEDAL_EN
            RELEASE: begin
                if (last) state_nx = IDLE;
            end
`endif
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            idx        <= '0;
            lat_on     <= 1'b0;
            lat_note   <= '0;
            lat_vel    <= '0;
            cand_idx   <= '0;
            cand_cls   <= CLS_S;
            cand_age   <= '0;
            keys_on    <= '0;
            hold_voice <= '0;
            hold_note  <= '0;
            hold_vel   <= '0;
            for (int i = 0; i < VOICES; i++) begin
                note_tab[i] <= '0;
                age_tab[i]  <= '0;
            end
`ifdef SUSTAIN_PEDAL_EN
            held     <= '0;
            sus_q    <= 1'b0;
            sus_pend <= 1'b0;
`endif
        end else begin
            if (asg_valid) begin
                hold_voice <= asg_voice;
                hold_note  <= asg_note;
                hold_vel   <= asg_vel;
            end
`ifdef SUSTAIN_PEDAL_EN
            sus_q <= sustain;
            if (state == IDLE) begin
                sus_pend <= 1'b0;
            end else if (sus_q & ~sustain) begin
                sus_pend <= 1'b1;
            end
`endif
            case (state)
                IDLE: begin
                    idx <= '0;
                    if (accept) begin
                        // Velocity-zero note-on is the running-status form of note-off.
                        lat_on   <= ev_on & (ev_vel != 7'd0);
                        lat_note <= ev_note;
                        lat_vel  <= ev_vel;
                    end
                end
                SCAN: begin
                    idx      <= idx + 1'b1;
                    cand_idx <= nx_idx;
                    cand_cls <= nx_cls;
                    cand_age <= nx_age;
                    if (noff_pulse) keys_on[idx] <= 1'b0;
`ifdef SUSTAIN_PEDAL_EN
                    if (noff_hit & sustain) held[idx] <= 1'b1;
`endif
                    // Commit the winner as the scan closes so the table is current during ASSIGN.
                    if (last && lat_on) begin
                        keys_on[nx_idx]  <= 1'b1;
                        note_tab[nx_idx] <= lat_note;
`ifdef SUSTAIN_PEDAL_EN
                        held[nx_idx] <= 1'b0;
`endif
                        for (int i = 0; i < VOICES; i++) begin
                            if (VW'(i) == nx_idx) begin
                                age_tab[i] <= '0;
                            end else if (age_tab[i] != AGE_MAX) begin
                                age_tab[i] <= age_tab[i] + 1'b1;
                            end
                        end
                    end
                end
`ifdef SUSTAIN_PEDAL_EN
                RELEASE: begin
                    idx <= idx + 1'b1;
                    if (held[idx]) begin
                        held[idx]    <= 1'b0;
                        keys_on[idx] <= 1'b0;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;
    localparam int VOICES = 32;
    localparam int AGE_W  = 8;
    localparam int VW     = 5;
    localparam int AGE_SAT = (1 << AGE_W) - 1;

    logic              CLOCK_50 = 1'b0;
    logic              reset_n;
    logic              ev_valid;
    logic              ev_ready;
    logic              ev_on;
    logic [6:0]        ev_note;
    logic [6:0]        ev_vel;
    logic [VOICES-1:0] voice_free;
`ifdef SUSTAIN_PEDAL_EN
    logic              sustain;
`endif
    logic              asg_valid;
    logic              asg_on;
    logic [VW-1:0]     asg_voice;
    logic [6:0]        asg_note;
    logic [6:0]        asg_vel;
    logic              asg_steal;
    logic [VOICES-1:0] keys_on;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit m_keys [VOICES];
    int m_note [VOICES];
    int m_age  [VOICES];
    bit m_held [VOICES];
    int hv, hn, hvl;

    voice_allocator #(.VOICES(VOICES), .AGE_W(AGE_W)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_on      (ev_on),
        .ev_note    (ev_note),
        .ev_vel     (ev_vel),
        .voice_free (voice_free),
`ifdef SUSTAIN_PEDAL_EN
        .sustain    (sustain),
`endif
        .asg_valid  (asg_valid),
        .asg_on     (asg_on),
        .asg_voice  (asg_voice),
        .asg_note   (asg_note),
        .asg_vel    (asg_vel),
        .asg_steal  (asg_steal),
        .keys_on    (keys_on)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, req);
        end
    endtask

    function automatic logic [VOICES-1:0] mkeys();
        logic [VOICES-1:0] k;
        for (int i = 0; i < VOICES; i++) k[i] = m_keys[i];
        return k;
    endfunction

    function automatic bit sus_now();
`ifdef SUSTAIN_PEDAL_EN
        return sustain;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < VOICES; i++) begin
            m_keys[i] = 0; m_note[i] = 0; m_age[i] = 0; m_held[i] = 0;
        end
        hv = 0; hn = 0; hvl = 0;
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        reset_n = 1'b0;
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        model_reset();
    endtask

    // Class of voice i for a note-on of note n: 3=retrigger, 2=free, 1=releasing, 0=steal.
    function automatic int vclass(input int i, input int n);
        if (m_keys[i]) return (m_note[i] == n) ? 3 : 0;
        return voice_free[i] ? 2 : 1;
    endfunction

    task automatic do_event(input bit on, input int note, input int vel);
        bit eff_on;
        bit offm [VOICES];
        int best;
        int bcls;
        int w;
        bit req_v;
        eff_on = on && (vel != 0);
        best = -1;
        bcls = 0;
        w = 0;
        while (ev_ready !== 1'b1 && w < 200) begin
            @(negedge CLOCK_50);
            w++;
        end
        chk("ready_wait", ev_ready, 1);
        // Model: choose best class first, then oldest within class (free: lowest index).
        for (int c = 3; c >= 0 && best < 0; c--) begin
            for (int i = 0; i < VOICES; i++) begin
                if (vclass(i, note) == c && (best < 0 || (c != 2 && m_age[i] > m_age[best]))) best = i;
            end
            bcls = c;
        end
        for (int i = 0; i < VOICES; i++) offm[i] = !eff_on && m_keys[i] && (m_note[i] == note) && !sus_now();
        ev_valid = 1'b1;
        ev_on    = on;
        ev_note  = 7'(note);
        ev_vel   = 7'(vel);
        @(posedge CLOCK_50);
        #1;
        ev_valid = 1'b0;
        for (int cyc = 1; cyc <= VOICES + 1; cyc++) begin
            @(negedge CLOCK_50);
            req_v = (cyc <= VOICES) ? offm[cyc-1] : eff_on;
            chk("asg_valid", asg_valid, req_v);
            chk("asg_steal", asg_steal, req_v && eff_on && (bcls == 0));
            chk("ev_ready_busy", ev_ready, 0);
            if (req_v) begin
                chk("asg_on", asg_on, eff_on);
                chk("asg_voice", asg_voice, eff_on ? best : cyc - 1);
                chk("asg_note", asg_note, note);
                chk("asg_vel", asg_vel, vel);
                hv = eff_on ? best : cyc - 1; hn = note; hvl = vel;
            end
            if (cyc <= VOICES && !eff_on && m_keys[cyc-1] && m_note[cyc-1] == note) begin
                if (sus_now()) m_held[cyc-1] = 1;
                else m_keys[cyc-1] = 0;
            end
            if (cyc == VOICES + 1) begin
                if (eff_on) begin
                    for (int i = 0; i < VOICES; i++) begin
                        if (i == best) m_age[i] = 0;
                        else if (m_age[i] < AGE_SAT) m_age[i]++;
                    end
                    m_keys[best] = 1; m_note[best] = note; m_held[best] = 0;
                end
                chk("keys_on_assign", keys_on, mkeys());
            end
        end
        @(negedge CLOCK_50);
        chk("ready_back", ev_ready, 1);
        chk("hold_voice", asg_voice, hv);
        chk("hold_note", asg_note, hn);
        chk("hold_vel", asg_vel, hvl);
        chk("idle_steal", asg_steal, 0);
    endtask

    initial begin
        bit seen;
        int npulse;
        int nheld;
        reset_n    = 1'b0;
        ev_valid   = 1'b0;
        ev_on      = 1'b0;
        ev_note    = '0;
        ev_vel     = '0;
        voice_free = '1;
`ifdef SUSTAIN_PEDAL_EN
        sustain    = 1'b0;
`endif
        model_reset();
        #12;
        chk("rst_ready", ev_ready, 1);
        chk("rst_valid", asg_valid, 0);
        chk("rst_keys", keys_on, 0);
        chk("rst_voice", asg_voice, 0);
        chk("rst_steal", asg_steal, 0);
        @(negedge CLOCK_50);
        reset_n = 1'b1;

        // First note lands on the lowest free voice.
        do_event(1, 60, 100);
        chk("t1_keys", keys_on, 32'h1);
        // Release of a middle note.
        do_event(1, 62, 100);
        do_event(1, 64, 100);
        do_event(0, 62, 64);
        chk("t2_keys", keys_on, 32'h5);
        // Retrigger of a held key.
        do_event(1, 60, 90);
        chk("t3_keys", keys_on, 32'h5);

        // Fill every voice, then steal the oldest.
        do_reset();
        for (int i = 0; i < VOICES; i++) do_event(1, 67 + i, 80);
        chk("t4_full", keys_on, 32'hFFFF_FFFF);
        do_event(1, 100, 80);
        // Velocity-zero note-on releases voice 3 (note 70).
        do_event(1, 70, 0);

        // Reset in the middle of a scan aborts the event.
        @(negedge CLOCK_50);
        ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd50; ev_vel = 7'd10;
        @(posedge CLOCK_50);
        #1;
        ev_valid = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        reset_n = 1'b0;
        #1;
        chk("abort_keys", keys_on, 0);
        chk("abort_ready", ev_ready, 1);
        chk("abort_valid", asg_valid, 0);
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        model_reset();
        seen = 0;
        for (int c = 0; c < VOICES + 3; c++) begin
            @(negedge CLOCK_50);
            seen = seen | asg_valid;
        end
        chk("abort_no_asg", seen, 0);

        // Randomized events over a narrow note range to exercise all classes.
        for (int n = 0; n < 60; n++) begin
            voice_free = VOICES'($urandom);
            do_event($urandom_range(0, 2) != 0, 60 + $urandom_range(0, 9),
                     ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 127));
        end

`ifdef SUSTAIN_PEDAL_EN
        do_reset();
        voice_free = '1;
        sustain = 1'b1;
        do_event(1, 60, 90);
        do_event(0, 60, 40);
        chk("sus_keys_held", keys_on[0], 1);
        @(negedge CLOCK_50);
        sustain = 1'b0;
        npulse = 0;
        nheld = 0;
        for (int i = 0; i < VOICES; i++) nheld += m_held[i];
        for (int c = 0; c < VOICES + 4; c++) begin
            @(negedge CLOCK_50);
            if (asg_valid) begin
                npulse++;
                chk("sus_rel_on", asg_on, 0);
                chk("sus_rel_voice_held", m_held[asg_voice], 1);
            end
        end
        chk("sus_rel_count", npulse, nheld);
        for (int i = 0; i < VOICES; i++) if (m_held[i]) begin m_keys[i] = 0; m_held[i] = 0; end
        chk("sus_rel_keys", keys_on, mkeys());
        chk("sus_ready", ev_ready, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
